apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Two-requester APB master that shares the single APB bus to the GPIO/UART peripheral slaves. It accepts transfer requests from two local requesters (host command path and UART command path), arbitrates round-robin, and sequences the APB SETUP/ACCESS phases. It waits on PREADY, aborts on timeout, and returns read data plus a completion pulse to the granted requester. It sits between the requesters and the APB slave-select/decode logic.

## Interface
- ADDR_W, 4, APB address width
- DATA_W, 8, APB data width
- TIMEOUT, 15, max ACCESS cycles without PREADY before abort (≥1)

- PCLK  in  1  clock, all state on rising edge
- PRESET  in  1  asynchronous, active-high reset
- req_valid  in  2  request pending per requester; held until accepted
- req_write  in  2  per-requester direction (1 = write)
- req_addr  in  2*ADDR_W  per-requester address; requester i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  per-requester write data, same packing
- req_accept  out  2  one-hot, combinational; high the cycle request fields are captured
- rsp_done  out  2  one-hot, 1-cycle completion pulse to the owning requester
- rsp_err  out  1  valid with rsp_done; 1 = timeout abort
- rsp_rdata  out  DATA_W  read data, valid with rsp_done on reads
- PSEL, PENABLE, PWRITE  out  1  APB master controls
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB slave ready
- busy  out  1  high in SETUP or ACCESS
- grant_id  out  1  index of the current/last granted requester

## Operation
- States: IDLE, SETUP, ACCESS. Reset → IDLE.
- IDLE:
  - If any req_valid is set, select a winner by round-robin.
  - Priority pointer `rr`: the requester not granted last has priority. `rr` resets to 0, so requester 0 wins the first tie.
  - Assert req_accept[winner] combinationally.
  - Latch addr/write/wdata into PADDR/PWRITE/PWDATA, set grant_id, go to SETUP.
- SETUP: PSEL=1, PENABLE=0, one cycle, then ACCESS; clear timeout counter.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1 on a clock edge: complete.
    - Next cycle: rsp_done[grant_id]=1, rsp_err=0.
    - rsp_rdata = captured PRDATA if a read; retains its previous value if a write.
    - Pointer updates to the other requester; go to IDLE.
  - PREADY=0: counter increments. When the counter reaches TIMEOUT-1 with PREADY still low, abort.
    - Next cycle: rsp_done[grant_id]=1, rsp_err=1, rsp_rdata=0.
    - Pointer updates; go to IDLE.
- PADDR/PWRITE/PWDATA are stable from SETUP through the end of ACCESS. They hold their last values in IDLE.
- req_valid dropping after accept has no effect on the in-flight transfer.
- Requests arriving while busy wait; req_accept is 0 outside IDLE.
- Counter width: clog2(TIMEOUT)+1; it never wraps, because the abort fires first.

## Timing
- Reset values:
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0
  - rsp_done, rsp_err, rsp_rdata = 0; busy = 0; grant_id = 0; rr = 0; state = IDLE
- Reset asserted mid-transfer: immediately drop PSEL/PENABLE to 0 and return to IDLE. No rsp_done is issued for the killed transfer.
- Zero-wait transfer:
  - cycle 0: IDLE, accept
  - cycle 1: SETUP
  - cycle 2: ACCESS, PREADY=1
  - cycle 3: IDLE with rsp_done; a new accept is allowed in cycle 3
- Throughput: one transfer per 3 cycles with no wait states. Each wait state adds 1 cycle.
- Timeout: with PREADY held low, ACCESS lasts exactly TIMEOUT cycles; rsp_done with rsp_err follows in the next cycle.
- rsp_done and req_accept may be high in the same cycle (completion and new grant).
- PREADY is ignored outside ACCESS.

## Test plan
- Write: req_valid=01, addr=4'h2, wdata=8'hA5, write=1, PREADY tied 1.
  - Required: accept[0] in cycle 0; PSEL in cycle 1; PSEL&PENABLE with PADDR=2, PWDATA=A5 in cycle 2; rsp_done=01, err=0 in cycle 3.
- Read: requester 1, addr=4'h1, PRDATA=8'h3C, PREADY=1.
  - Required: rsp_done=10, rsp_rdata=3C, PWRITE=0 throughout.
- Contention: req_valid=11 held for 4 transfers, PREADY=1.
  - Required: grant order 0,1,0,1; each accept is 3 cycles apart.
- Wait states: PREADY low for the first 3 ACCESS cycles, then high.
  - Required: ACCESS lasts 4 cycles, address/data stable throughout, rsp_done one cycle after PREADY.
- Timeout: TIMEOUT=15, PREADY never asserted.
  - Required: exactly 15 ACCESS cycles, then rsp_done with rsp_err=1, rsp_rdata=0.
  - A subsequent request then completes normally.
- Reset mid-ACCESS: assert PRESET asynchronously.
  - Required: PSEL/PENABLE go 0 without waiting for a clock edge; no rsp_done; after release, requester 0 wins a tie.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin APB master with a wait-state timeout.
// Transfer fields are latched on accept and stay on the bus until the next accept.
module apb_master_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_accept,
    output logic [1:0]          rsp_done,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    output logic                busy,
    output logic                grant_id
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              r_state, w_next;
    logic                r_rr, r_grant, r_pwrite, r_err;
    logic [1:0]          r_done;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata, r_rdata;
    logic [CW-1:0]       r_cnt;
    logic                w_any, w_win, w_start, w_ready, w_tout, w_end;

    always_comb begin
        w_any      = |req_valid;
        w_win      = (&req_valid) ? r_rr : req_valid[1];
        w_start    = (r_state == IDLE) && w_any;
        w_ready    = (r_state == ACCESS) && PREADY;
        // abort on the TIMEOUT-th ACCESS cycle that still sees no PREADY
        w_tout     = (r_state == ACCESS) && !PREADY && (r_cnt == CW'(TIMEOUT - 1));
        w_end      = w_ready || w_tout;
        w_next     = r_state;
        w_next     = (r_state == IDLE)   ? (w_any ? SETUP : IDLE) :
                     (r_state == SETUP)  ? ACCESS :
                     (w_end ? IDLE : ACCESS);
        req_accept = w_start ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_rr     <= 1'b0;
            r_grant  <= 1'b0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_cnt    <= '0;
            r_done   <= 2'b00;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_done <= 2'b00;
            r_err  <= 1'b0;
            if (w_start) begin
                r_grant  <= w_win;
                r_pwrite <= w_win ? req_write[1] : req_write[0];
                r_paddr  <= w_win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                r_pwdata <= w_win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            end
            if (r_state == SETUP) r_cnt <= '0;
            if ((r_state == ACCESS) && !PREADY && !w_tout) r_cnt <= r_cnt + CW'(1);
            if (w_end) begin
                r_done  <= r_grant ? 2'b10 : 2'b01;
                r_err   <= w_tout;
                r_rr    <= ~r_grant;
                r_rdata <= w_tout ? '0 : (r_pwrite ? r_rdata : PRDATA);
            end
        end
    end

    assign PSEL      = (r_state != IDLE);
    assign PENABLE   = (r_state == ACCESS);
    assign busy      = PSEL;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign grant_id  = r_grant;
    assign rsp_done  = r_done;
    assign rsp_err   = r_err;
    assign rsp_rdata = r_rdata;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed stimulus, transaction-level reference model
// compared every cycle, plus literal cycle-by-cycle expectations.
module tb_apb_master_arbiter;
    localparam int TIMEOUT = 15;

    logic       PCLK = 1'b0, PRESET = 1'b1;
    logic [1:0] req_valid = 2'b00, req_write = 2'b00;
    logic [7:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0] req_accept, rsp_done;
    logic       rsp_err, PSEL, PENABLE, PWRITE, busy, grant_id;
    logic [7:0] rsp_rdata, PWDATA, PRDATA = '0;
    logic [3:0] PADDR;
    logic       PREADY = 1'b0;

    int n_checks = 0, n_pass = 0;
    int wait_n = 0, acc_cnt = 0;
    bit never = 1'b0;

    apb_master_arbiter #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_accept(req_accept),
        .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .busy(busy),
        .grant_id(grant_id)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    // slave: PREADY low for wait_n ACCESS cycles (forever if never), high otherwise
    always @(posedge PCLK or posedge PRESET) begin
        #1;
        if (PSEL && PENABLE) begin
            PREADY = !never && (acc_cnt >= wait_n);
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            PREADY = !never;
        end
    end

    // reference model: one transfer at a time, tracked by age since accept
    bit         m_active, m_write, m_err, m_grant;
    int         m_owner, m_age, m_rr;
    logic [3:0] m_addr;
    logic [7:0] m_wdata, m_rdata;
    logic [1:0] m_done, exp_acc;

    always @(negedge PCLK) begin
        if (PRESET) begin
            m_active = 0; m_rr = 0; m_grant = 0; m_write = 0; m_addr = 0;
            m_wdata = 0; m_done = 0; m_err = 0; m_rdata = 0; m_age = 0; m_owner = 0;
        end
        exp_acc = 2'b00;
        if (!m_active && req_valid != 2'b00)
            exp_acc = (req_valid == 2'b11) ? 2'(1 << m_rr) : req_valid;
        chk("accept", req_accept, exp_acc);
        chk("psel", PSEL, m_active);
        chk("penable", PENABLE, m_active && m_age >= 2);
        chk("busy", busy, m_active);
        chk("pwrite", PWRITE, m_write);
        chk("paddr", PADDR, m_addr);
        chk("pwdata", PWDATA, m_wdata);
        chk("grant_id", grant_id, m_grant);
        chk("rsp_done", rsp_done, m_done);
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        if (!PRESET) begin
            m_done = 0;
            m_err = 0;
            if (m_active) begin
                if (m_age == 1) m_age = 2;
                else if (PREADY || m_age - 1 == TIMEOUT) begin
                    m_done = 2'(1 << m_owner);
                    m_err = !PREADY;
                    m_rdata = !PREADY ? 8'h00 : (m_write ? m_rdata : PRDATA);
                    m_rr = 1 - m_owner;
                    m_active = 0;
                end else m_age++;
            end else if (req_valid != 2'b00) begin
                m_owner = (req_valid == 2'b11) ? m_rr : (req_valid[1] ? 1 : 0);
                m_grant = m_owner[0];
                m_addr = req_addr[m_owner*4 +: 4];
                m_wdata = req_wdata[m_owner*8 +: 8];
                m_write = req_write[m_owner];
                m_active = 1;
                m_age = 1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] order [4];
        order = '{2'b01, 2'b10, 2'b01, 2'b10};
        tick; tick; tick;
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("reset_psel", PSEL, 0);
        chk("reset_grant", grant_id, 0);
        chk("reset_rdata", rsp_rdata, 0);
        tick;
        // write from requester 0, zero wait
        req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h02; req_wdata = 16'h00A5;
        @(negedge PCLK); chk("wr_accept_c0", req_accept, 2'b01);
        tick; req_valid = 2'b00;
        @(negedge PCLK); chk("wr_setup_c1", {PSEL, PENABLE}, 2'b10);
        tick;
        @(negedge PCLK); chk("wr_access_c2", {PSEL, PENABLE, PADDR, PWDATA}, {2'b11, 4'h2, 8'hA5});
        tick;
        @(negedge PCLK); chk("wr_done_c3", {rsp_done, rsp_err}, {2'b01, 1'b0});
        tick;
        // read from requester 1
        req_valid = 2'b10; req_write = 2'b00; req_addr = 8'h10; PRDATA = 8'h3C;
        @(negedge PCLK); chk("rd_accept_c0", req_accept, 2'b10);
        tick; req_valid = 2'b00;
        tick;
        @(negedge PCLK); chk("rd_pwrite_c2", {PENABLE, PWRITE}, 2'b10);
        tick;
        @(negedge PCLK); chk("rd_done_c3", {rsp_done, rsp_rdata}, {2'b10, 8'h3C});
        tick;
        // contention: both held for four transfers
        req_valid = 2'b11; req_write = 2'b01; req_addr = 8'h65; req_wdata = 16'h9911; PRDATA = 8'h77;
        for (int k = 0; k < 4; k++) begin
            @(negedge PCLK); chk("rr_accept", req_accept, order[k]);
            tick;
            if (k == 3) req_valid = 2'b00;
            @(negedge PCLK); chk("rr_gap", req_accept, 2'b00);
            tick; tick;
        end
        tick; tick;
        // wait states: PREADY low for three ACCESS cycles
        wait_n = 3;
        req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h07; req_wdata = 16'h005A;
        @(negedge PCLK); chk("ws_accept", req_accept, 2'b01);
        tick; req_valid = 2'b00;
        tick; tick; tick;
        @(negedge PCLK); chk("ws_c4", {PENABLE, rsp_done}, {1'b1, 2'b00});
        tick;
        @(negedge PCLK); chk("ws_c5", {PENABLE, PADDR, PWDATA}, {1'b1, 4'h7, 8'h5A});
        tick;
        @(negedge PCLK); chk("ws_done_c6", {PSEL, rsp_done, rsp_err}, {1'b0, 2'b01, 1'b0});
        tick;
        // timeout: PREADY never asserted
        wait_n = 0; never = 1'b1;
        req_valid = 2'b10; req_write = 2'b00; req_addr = 8'h30; PRDATA = 8'hFF;
        tick; req_valid = 2'b00;
        for (int c = 1; c < 16; c++) tick;
        @(negedge PCLK); chk("to_c16", {PENABLE, rsp_done}, {1'b1, 2'b00});
        tick;
        @(negedge PCLK); chk("to_done_c17", {PSEL, rsp_done, rsp_err, rsp_rdata}, {1'b0, 2'b10, 1'b1, 8'h00});
        tick;
        never = 1'b0;
        req_valid = 2'b10; req_addr = 8'h40; PRDATA = 8'h66;
        tick; req_valid = 2'b00;
        tick; tick;
        @(negedge PCLK); chk("after_to_done", {rsp_done, rsp_err, rsp_rdata}, {2'b10, 1'b0, 8'h66});
        tick;
        // asynchronous reset during ACCESS
        never = 1'b1;
        req_valid = 2'b10; req_addr = 8'h50;
        tick; req_valid = 2'b00;
        tick;
        #2 PRESET = 1'b1;
        #1 chk("async_rst", {PSEL, PENABLE, busy}, 3'b000);
        tick; tick;
        PRESET = 1'b0; never = 1'b0;
        req_valid = 2'b11; req_write = 2'b11; req_addr = 8'h9A; req_wdata = 16'hC3E1;
        @(negedge PCLK); chk("rst_tie", {req_accept, rsp_done}, {2'b01, 2'b00});
        tick; req_valid = 2'b00;
        tick; tick;
        @(negedge PCLK); chk("rst_after_done", rsp_done, 2'b01);
        tick; tick;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
